// File: rtl/pu_topic_io_req_if.sv
// Command type and core/memory-side bundle for the per-PU topic PD memory initiator.
// The package supplies default definitions for the platform macros when the build does not provide them.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 31:28
`endif
`ifndef PU_TOPIC_MEM
`define PU_TOPIC_MEM 4'h2
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

package pu_topic_io_pkg;
    typedef struct packed {
        logic [31:0]                 addr;
        logic [3:0]                  tid;
        logic                        wr;
        logic                        atomic;
        logic [4:0]                  funct5;
        logic [`PU_WIDTH_NBITS-1:0]  wdata;
    } io_type;
endpackage

// core_req/core_ready: a request transfers on every cycle where both are high, and core_cmd
// must be held while core_req is high and core_ready is low. io_req is a one-cycle issue pulse
// and the transaction stays open, with io_cmd stable, until the memory returns io_ack.
interface pu_topic_io_req_if
    import pu_topic_io_pkg::*;
#(
    parameter int WIDTH_NBITS = `PU_WIDTH_NBITS
);
    logic                   core_req;
    logic                   core_ready;
    io_type                 core_cmd;
    logic                   core_rvalid;
    logic [WIDTH_NBITS-1:0] core_rdata;
    logic                   core_err;
    logic                   io_req;
    io_type                 io_cmd;
    logic                   io_ack;
    logic [WIDTH_NBITS-1:0] io_ack_data;

    modport slave (
        input  core_req, core_cmd, io_ack, io_ack_data,
        output core_ready, core_rvalid, core_rdata, core_err, io_req, io_cmd
    );
    modport master (
        output core_req, core_cmd, io_ack, io_ack_data,
        input  core_ready, core_rvalid, core_rdata, core_err, io_req, io_cmd
    );
endinterface

// File: rtl/pu_topic_io_req.sv
// Per-PU initiator: queues core requests and issues them one at a time to the topic PD memory.
// Optional ack timeout with stale-ack drain is enabled by defining PU_TOPIC_IO_TIMEOUT_EN.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 31:28
`endif
`ifndef PU_TOPIC_MEM
`define PU_TOPIC_MEM 4'h2
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module pu_topic_io_req
    import pu_topic_io_pkg::*;
#(
    parameter int WIDTH_NBITS   = `PU_WIDTH_NBITS,
    parameter int QDEPTH        = 2,
    parameter int TIMEOUT_NBITS = 10
) (
    input  logic             clk,
    input  logic             `RESET_SIG,
    pu_topic_io_req_if.slave bus,
    output logic [2:0]       state_dbg
);
    localparam int PW = $clog2(QDEPTH);

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || TIMEOUT_NBITS < 1 ||
        WIDTH_NBITS != `PU_WIDTH_NBITS) begin : g_bad_params
        $error("pu_topic_io_req: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
`ifdef PU_TOPIC_IO_TIMEOUT_EN
        , S_DRAIN = 3'd5
`endif
    } state_t;

    state_t                 state;
    io_type                 queue_mem [QDEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   region_ok;
    io_type                 head;
    logic [WIDTH_NBITS-1:0] ack_data;
`ifdef PU_TOPIC_IO_TIMEOUT_EN
    logic [TIMEOUT_NBITS-1:0] to_cnt;
`endif

    assign full           = (count == (PW+1)'(QDEPTH));
    assign empty          = (count == '0);
    assign bus.core_ready = ~full;
    assign push           = bus.core_req & ~full;
    assign pop            = (state == S_IDLE) & ~empty;
    assign head           = queue_mem[rd_ptr];
    assign region_ok      = (head.addr[`PU_MEM_MULTI_DEPTH_RANGE] == `PU_TOPIC_MEM);
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (push) queue_mem[wr_ptr] <= bus.core_cmd;
    end

    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            ack_data        <= '0;
            bus.io_req      <= 1'b0;
            bus.io_cmd      <= '0;
            bus.core_rvalid <= 1'b0;
            bus.core_rdata  <= '0;
            bus.core_err    <= 1'b0;
`ifdef PU_TOPIC_IO_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            bus.io_req      <= 1'b0;
            bus.core_rvalid <= 1'b0;
            bus.core_rdata  <= '0;
            bus.core_err    <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.io_cmd <= head;
                        if (region_ok) begin
                            bus.io_req <= 1'b1;
                            state      <= S_ISSUE;
`ifdef PU_TOPIC_IO_TIMEOUT_EN
                            to_cnt     <= '0;
`endif
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef PU_TOPIC_IO_TIMEOUT_EN
                    // The issue cycle counts, so the error pulse lands 2^N cycles after io_req.
                    to_cnt <= to_cnt + TIMEOUT_NBITS'(1);
`endif
                end
                S_WAIT: begin
                    if (bus.io_ack) begin
                        ack_data <= bus.io_ack_data;
                        state    <= S_RESP;
                    end
`ifdef PU_TOPIC_IO_TIMEOUT_EN
                    else if (to_cnt == '1) begin
                        bus.core_rvalid <= 1'b1;
                        bus.core_err    <= 1'b1;
                        state           <= S_DRAIN;
                    end else begin
                        to_cnt <= to_cnt + TIMEOUT_NBITS'(1);
                    end
`endif
                end
                S_RESP: begin
                    bus.core_rvalid <= 1'b1;
                    bus.core_rdata  <= (bus.io_cmd.wr && !bus.io_cmd.atomic) ? '0 : ack_data;
                    state           <= S_IDLE;
                end
                S_ERR: begin
                    bus.core_rvalid <= 1'b1;
                    bus.core_err    <= 1'b1;
                    state           <= S_IDLE;
                end
`ifdef PU_TOPIC_IO_TIMEOUT_EN
                S_DRAIN: begin
                    // The memory still owes an ack for the abandoned request; swallow it.
                    if (bus.io_ack) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pu_topic_io_req.sv
// Bench for pu_topic_io_req: memory responder model plus an expected-completion queue.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 31:28
`endif
`ifndef PU_TOPIC_MEM
`define PU_TOPIC_MEM 4'h2
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_pu_topic_io_req;
    import pu_topic_io_pkg::*;
    localparam int W = `PU_WIDTH_NBITS;
`ifdef PU_TOPIC_IO_TIMEOUT_EN
    localparam int TO_NBITS = 4;
`else
    localparam int TO_NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_dbg;
    int         cyc = 0;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [W:0] exp_q[$];

    // memory model controls and observations
    bit         mem_en;
    int         ack_delay;
    logic [W-1:0] ack_value;
    int         req_seen = 0;
    int         overlap_cnt = 0;
    int         unstable_cnt = 0;
    int         gap_viol = 0;
    int         last_req_cyc = 0;
    int         last_ack_cyc = -100;
    int         accept_cyc = 0;
    io_type     last_cmd;

    pu_topic_io_req_if #(.WIDTH_NBITS(W)) bus();

    pu_topic_io_req #(.WIDTH_NBITS(W), .QDEPTH(2), .TIMEOUT_NBITS(TO_NBITS)) dut (
        .clk       (clk),
        .`RESET_SIG(rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder: acks ack_delay cycles after io_req with ack_value ^ addr[7:0].
    initial begin : mem_model
        io_type held;
        bus.io_ack = 1'b0;
        bus.io_ack_data = '0;
        forever begin
            @(negedge clk);
            bus.io_ack = 1'b0;
            if (bus.io_req === 1'b1) begin
                req_seen++;
                if (cyc - last_ack_cyc < 3) gap_viol++;
                last_req_cyc = cyc;
                last_cmd = bus.io_cmd;
                held = bus.io_cmd;
                if (mem_en) begin
                    for (int k = 0; k < ack_delay; k++) begin
                        @(negedge clk);
                        if (bus.io_req === 1'b1) overlap_cnt++;
                        if (bus.io_cmd !== held) unstable_cnt++;
                    end
                    bus.io_ack = 1'b1;
                    bus.io_ack_data = ack_value ^ W'(held.addr[7:0]);
                    last_ack_cyc = cyc;
                end
            end
        end
    end

    function automatic io_type mk(input logic [31:0] addr, input logic [3:0] tid, input logic wr,
                                  input logic atomic, input logic [4:0] funct5, input logic [W-1:0] wdata);
        io_type c;
        c.addr = addr; c.tid = tid; c.wr = wr; c.atomic = atomic; c.funct5 = funct5; c.wdata = wdata;
        return c;
    endfunction

    function automatic logic [W:0] exp_for(input io_type c);
        if (c.addr[`PU_MEM_MULTI_DEPTH_RANGE] != `PU_TOPIC_MEM) return {1'b1, {W{1'b0}}};
        if (c.wr && !c.atomic) return '0;
        return {1'b0, ack_value ^ W'(c.addr[7:0])};
    endfunction

    task automatic send(input io_type c);
        int n = 0;
        @(negedge clk);
        bus.core_req = 1'b1;
        bus.core_cmd = c;
        while (bus.core_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.core_ready === 1'b1) begin
            exp_q.push_back(exp_for(c));
            accept_cyc = cyc;
        end else begin
            total_cnt++;
            $display("FAIL send_accept: core_ready stuck at %b, required 1", bus.core_ready);
        end
        @(posedge clk);
        #1 bus.core_req = 1'b0;
    endtask

    task automatic wait_rvalid(input int budget, output bit got, output logic [W:0] obs, output int at);
        got = 1'b0; obs = '0; at = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.core_rvalid === 1'b1) begin
                got = 1'b1;
                obs = {bus.core_err, bus.core_rdata};
                at  = cyc;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total_cnt++;
        if ({bus.core_ready, bus.core_rvalid, bus.core_err, bus.io_req, state_dbg} !== 7'b1000000)
            $display("FAIL reset_ctrl: ready/rvalid/err/io_req/state=%b required 1000000",
                     {bus.core_ready, bus.core_rvalid, bus.core_err, bus.io_req, state_dbg});
        else pass_cnt++;
        total_cnt++;
        if ({bus.core_rdata, bus.io_cmd} !== '0)
            $display("FAIL reset_data: rdata=%h io_cmd=%h required 0", bus.core_rdata, bus.io_cmd);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_load;
        io_type c; bit got; logic [W:0] obs, e; int at, r0;
        mem_en = 1'b1; ack_delay = 4; ack_value = W'(32'h1234);
        c = mk(32'h2000_0100, 4'd3, 1'b0, 1'b0, 5'd0, W'(0));
        r0 = req_seen;
        send(c);
        wait_rvalid(100, got, obs, at);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (!got) $display("FAIL load_rvalid: no completion, required one"); else pass_cnt++;
        total_cnt++; if (obs !== e) $display("FAIL load_data: got %h required %h", obs, e); else pass_cnt++;
        total_cnt++; if (req_seen - r0 !== 1) $display("FAIL load_io_req_count: got %0d required 1", req_seen - r0); else pass_cnt++;
        total_cnt++; if (last_cmd !== c) $display("FAIL load_io_cmd: got %h required %h", last_cmd, c); else pass_cnt++;
        total_cnt++; if (last_req_cyc - accept_cyc !== 2) $display("FAIL load_issue_latency: got %0d required 2", last_req_cyc - accept_cyc); else pass_cnt++;
        total_cnt++; if (at - last_ack_cyc !== 2) $display("FAIL load_resp_latency: got %0d required 2", at - last_ack_cyc); else pass_cnt++;
    endtask

    task automatic test_store;
        bit got; logic [W:0] obs, e; int at;
        logic [W-1:0] vals [2];
        vals[0] = '0;
        vals[1] = W'(32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            ack_value = vals[i];
            send(mk(32'h2000_0040, 4'd1, 1'b1, 1'b0, 5'd0, W'(32'hA5)));
            wait_rvalid(100, got, obs, at);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++; if (!got || obs !== e) $display("FAIL store_data[%0d]: got=%b %h required %h", i, got, obs, e); else pass_cnt++;
        end
    endtask

    task automatic test_atomic;
        io_type c; bit got; logic [W:0] obs, e; int at, u0;
        ack_value = W'(7); ack_delay = 6;
        c = mk(32'h2000_0200, 4'd5, 1'b1, 1'b1, 5'b00000, W'(32'h0000_0003));
        u0 = unstable_cnt;
        send(c);
        wait_rvalid(100, got, obs, at);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (!got || obs !== e) $display("FAIL atomic_old_value: got=%b %h required %h", got, obs, e); else pass_cnt++;
        total_cnt++; if (last_cmd.funct5 !== 5'b00000 || last_cmd.wdata !== c.wdata || !last_cmd.atomic)
            $display("FAIL atomic_io_cmd: got %h required %h", last_cmd, c); else pass_cnt++;
        total_cnt++; if (unstable_cnt !== u0) $display("FAIL atomic_cmd_stable: %0d changes, required 0", unstable_cnt - u0); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        bit got; logic [W:0] obs, e; int at, r0, o0, g0;
        ack_delay = 20; ack_value = W'(32'h0000_7700);
        r0 = req_seen; o0 = overlap_cnt; g0 = gap_viol;
        send(mk(32'h2000_0011, 4'd2, 1'b0, 1'b0, 5'd0, W'(0)));
        send(mk(32'h2000_0022, 4'd2, 1'b1, 1'b0, 5'd0, W'(32'h55)));
        send(mk(32'h2000_0033, 4'd2, 1'b0, 1'b0, 5'd0, W'(0)));
        total_cnt++; if (bus.core_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b required 0", bus.core_ready); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            wait_rvalid(100, got, obs, at);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++; if (!got || obs !== e) $display("FAIL b2b_order[%0d]: got=%b %h required %h", i, got, obs, e); else pass_cnt++;
        end
        total_cnt++; if (overlap_cnt !== o0) $display("FAIL b2b_outstanding: %0d overlapping io_req, required 0", overlap_cnt - o0); else pass_cnt++;
        total_cnt++; if (req_seen - r0 !== 3) $display("FAIL b2b_io_req_count: got %0d required 3", req_seen - r0); else pass_cnt++;
        total_cnt++; if (gap_viol !== g0) $display("FAIL b2b_gap: %0d io_req within 3 cycles of ack, required 0", gap_viol - g0); else pass_cnt++;
    endtask

    task automatic test_bad_region;
        bit got; logic [W:0] obs, e; int at, r0, t0;
        ack_delay = 3; ack_value = W'(32'h0000_0B00);
        r0 = req_seen;
        send(mk(32'h3000_0010, 4'd4, 1'b0, 1'b0, 5'd0, W'(0)));
        t0 = accept_cyc;
        wait_rvalid(100, got, obs, at);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (!got || obs !== e) $display("FAIL bad_region_err: got=%b %h required %h", got, obs, e); else pass_cnt++;
        total_cnt++; if (at - t0 !== 3) $display("FAIL bad_region_latency: got %0d required 3", at - t0); else pass_cnt++;
        total_cnt++; if (req_seen !== r0) $display("FAIL bad_region_no_io_req: got %0d io_req required 0", req_seen - r0); else pass_cnt++;
        send(mk(32'h2000_0044, 4'd4, 1'b0, 1'b0, 5'd0, W'(0)));
        wait_rvalid(100, got, obs, at);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (!got || obs !== e) $display("FAIL bad_region_next: got=%b %h required %h", got, obs, e); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait;
        bit got; logic [W:0] obs, e; int at, r0, n;
        mem_en = 1'b0;
        r0 = req_seen; n = 0;
        send(mk(32'h2000_0055, 4'd6, 1'b0, 1'b0, 5'd0, W'(0)));
        while (req_seen == r0 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        total_cnt++;
        if ({bus.core_ready, bus.core_rvalid, bus.core_err, bus.io_req, state_dbg} !== 7'b1000000 ||
            {bus.core_rdata, bus.io_cmd} !== '0)
            $display("FAIL wait_reset: ctrl=%b rdata=%h io_cmd=%h required 1000000/0/0",
                     {bus.core_ready, bus.core_rvalid, bus.core_err, bus.io_req, state_dbg}, bus.core_rdata, bus.io_cmd);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        #1 bus.io_ack = 1'b1; bus.io_ack_data = W'(32'h0000_0999);
        wait_rvalid(8, got, obs, at);
        total_cnt++; if (got) $display("FAIL stale_ack_ignored: core_rvalid=1 required 0"); else pass_cnt++;
        total_cnt++; if (state_dbg !== 3'd0) $display("FAIL stale_ack_state: got %0d required 0", state_dbg); else pass_cnt++;
        mem_en = 1'b1; ack_delay = 2; ack_value = W'(32'h0000_0C00);
        send(mk(32'h2000_0066, 4'd6, 1'b0, 1'b0, 5'd0, W'(0)));
        wait_rvalid(100, got, obs, at);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (!got || obs !== e) $display("FAIL after_reset_load: got=%b %h required %h", got, obs, e); else pass_cnt++;
    endtask

`ifdef PU_TOPIC_IO_TIMEOUT_EN
    task automatic test_timeout;
        bit got; logic [W:0] obs, e; int at;
        mem_en = 1'b0;
        send(mk(32'h2000_0077, 4'd7, 1'b0, 1'b0, 5'd0, W'(0)));
        wait_rvalid(60, got, obs, at);
        total_cnt++; if (!got || obs !== {1'b1, {W{1'b0}}}) $display("FAIL timeout_err: got=%b %h required err pulse", got, obs); else pass_cnt++;
        total_cnt++; if (at - last_req_cyc !== 16) $display("FAIL timeout_latency: got %0d required 16", at - last_req_cyc); else pass_cnt++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        total_cnt++; if (state_dbg !== 3'd5) $display("FAIL timeout_drain: state %0d required 5", state_dbg); else pass_cnt++;
        #1 bus.io_ack = 1'b1; bus.io_ack_data = W'(32'h0000_0AAA);
        wait_rvalid(6, got, obs, at);
        total_cnt++; if (got) $display("FAIL late_ack_discarded: core_rvalid=1 required 0"); else pass_cnt++;
        mem_en = 1'b1; ack_delay = 3; ack_value = W'(32'h0000_0D00);
        send(mk(32'h2000_0088, 4'd7, 1'b0, 1'b0, 5'd0, W'(0)));
        wait_rvalid(100, got, obs, at);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (!got || obs !== e) $display("FAIL timeout_next: got=%b %h required %h", got, obs, e); else pass_cnt++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.core_req = 1'b0;
        bus.core_cmd = '0;
        mem_en = 1'b1;
        ack_delay = 4;
        ack_value = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_load;
        test_store;
        test_atomic;
        test_back_to_back;
        test_bad_region;
        test_reset_in_wait;
`ifdef PU_TOPIC_IO_TIMEOUT_EN
        test_timeout;
`endif
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
